// File: rtl/core_pkg.sv
// core_pkg: RV32I constants shared by fetch, decode and the immediate extender,
// plus the fetch state encoding.
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO holding {instr, pc} pairs. Flush empties it in
// one cycle and overrides a simultaneous push or pop.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage, pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch. Owns the PC, keeps at most one word
// read outstanding, buffers returned words and handles branch redirects.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect target
// halts fetch and raises a sticky fetch_fault; otherwise low bits are masked).
//
// state   | meaning
// --------+------------------------------------------------------
// ST_RUN  | no request outstanding; request while FIFO has room
// ST_WAIT | one request accepted, waiting for its response
// ST_HALT | misaligned redirect seen; fetch stopped until rst
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  output logic            fetch_fault
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] w_fetch_pc_nxt;
  logic [XLEN-1:0] r_issue_pc;
  logic [XLEN-1:0] w_issue_pc_nxt;
  logic            r_discard;
  logic            w_discard_nxt;
  logic            w_accept;
  logic            w_redirect;
  logic            w_push;
  logic            w_pop;
  logic            w_flush;
  logic            w_fifo_empty;
  logic            w_fifo_full;
  logic [2*XLEN-1:0] w_head;
  logic [XLEN-1:0] w_target;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic w_misalign;
  logic w_fault_set;
  logic r_fault;
  assign w_target   = redirect_pc;
  assign w_misalign = (redirect_pc[1:0] != 2'b00);
`else
  logic [1:0] w_unused_lsb;
  assign w_target     = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_unused_lsb = redirect_pc[1:0];
`endif

  assign imem_req_valid = !rst && (r_state == ST_RUN) && !w_fifo_full;
  assign imem_req_addr  = r_fetch_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;
  assign w_redirect     = redirect_valid && (r_state != ST_HALT);
  assign dec_valid      = !w_fifo_empty;
  assign w_pop          = dec_valid && dec_ready;
  assign dec_instr      = w_head[2*XLEN-1:XLEN];
  assign dec_pc         = w_head[XLEN-1:0];

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (w_flush),
    .i_push      (w_push),
    .i_push_data ({imem_rsp_data, r_issue_pc}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_empty     (w_fifo_empty),
    .o_full      (w_fifo_full)
  );

  // Next-state, PC and FIFO control; a redirect overrides everything else.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_issue_pc_nxt = r_issue_pc;
    w_discard_nxt  = r_discard;
    w_push         = 1'b0;
    w_flush        = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    w_fault_set    = 1'b0;
`endif
    case (r_state)
      ST_RUN: begin
        // A response here is the stale one left over from a reset in WAIT.
        if (imem_rsp_valid) w_discard_nxt = 1'b0;
        if (w_accept) begin
          w_state_nxt    = ST_WAIT;
          w_issue_pc_nxt = r_fetch_pc;
          w_fetch_pc_nxt = r_fetch_pc + 32'd4;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          w_state_nxt   = ST_RUN;
          w_push        = !r_discard;
          w_discard_nxt = 1'b0;
        end
      end
      default: ;
    endcase
    if (w_redirect) begin
      w_flush        = 1'b1;
      w_push         = 1'b0;
      w_fetch_pc_nxt = w_target;
      if (w_accept || (r_state == ST_WAIT && !imem_rsp_valid)) w_discard_nxt = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (w_misalign) begin
        w_state_nxt = ST_HALT;
        w_fault_set = 1'b1;
      end
`endif
    end
  end

  // State register; reset in WAIT leaves one response in flight, so arm discard.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_fetch_pc <= RESET_PC;
      r_issue_pc <= RESET_PC;
      r_discard  <= (r_state == ST_WAIT) || (r_discard && !imem_rsp_valid);
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_issue_pc <= w_issue_pc_nxt;
      r_discard  <= w_discard_nxt;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)              r_fault <= 1'b0;
    else if (w_fault_set) r_fault <= 1'b1;
  end
  assign fetch_fault = r_fault;
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, table-driven bench for fetch_unit with a simple
// in-order memory model (1-cycle latency, response can be held back).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        fetch_fault;

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[23:0], 8'h13};
  endfunction

  // Memory model: answers an accepted request the next cycle unless held.
  logic        mem_hold = 1'b0;
  logic        r_pend   = 1'b0;
  logic [31:0] r_paddr  = 32'h0;
  always @(posedge clk) begin
    if (imem_rsp_valid) r_pend <= 1'b0;
    if (imem_req_valid && imem_req_ready) begin
      r_pend  <= 1'b1;
      r_paddr <= imem_req_addr;
    end
  end
  assign imem_rsp_valid = r_pend && !mem_hold;
  assign imem_rsp_data  = mem_word(r_paddr);

  typedef struct {
    logic        rdy;
    logic        hold;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_dec;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vt [18];

  function automatic vec_t mk(input logic rdy, input logic hold, input logic redir,
                              input logic [31:0] rpc, input logic e_req,
                              input logic [31:0] e_addr, input logic e_dec,
                              input logic [31:0] e_pc);
    vec_t v;
    v.rdy = rdy; v.hold = hold; v.redir = redir; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_dec = e_dec; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for two edges, then releases it; returns in post-reset cycle 0.
  task automatic do_reset();
    rst = 1'b1; imem_req_ready = 1'b0; mem_hold = 1'b0;
    dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    #1;
    chk("req_valid during reset", {31'b0, imem_req_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rdy hold red rpc            req addr           dec pc
    vt[0]  = mk(0, 0, 0, 32'h0,   1, 32'h0,   0, 32'h0);
    vt[1]  = mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
    vt[2]  = mk(0, 0, 0, 32'h0,   1, 32'h4,   1, 32'h0);
    vt[3]  = mk(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h0);
    vt[4]  = mk(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h0);
    vt[5]  = mk(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h0);
    vt[6]  = mk(1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h0);
    vt[7]  = mk(0, 0, 0, 32'h0,   1, 32'h8,   1, 32'h4);
    vt[8]  = mk(0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h4);
    vt[9]  = mk(0, 1, 1, 32'h100, 0, 32'h0,   1, 32'h4);
    vt[10] = mk(1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
    vt[11] = mk(1, 0, 0, 32'h0,   1, 32'h100, 0, 32'h0);
    vt[12] = mk(1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
    vt[13] = mk(0, 0, 0, 32'h0,   1, 32'h104, 1, 32'h100);
    vt[14] = mk(1, 0, 1, 32'h200, 0, 32'h0,   1, 32'h100);
    vt[15] = mk(1, 0, 0, 32'h0,   1, 32'h200, 0, 32'h0);
    vt[16] = mk(1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
    vt[17] = mk(1, 0, 0, 32'h0,   1, 32'h204, 1, 32'h200);

    // Reset state
    do_reset();
    chk("reset dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("reset dec_pc", dec_pc, 32'h0);
    chk("reset dec_instr", dec_instr, 32'h0);
    chk("reset fetch_fault", {31'b0, fetch_fault}, 32'd0);

    // Stall/fill, drain, redirect with outstanding request, redirect+pop+push
    imem_req_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      dec_ready      = vt[i].rdy;
      mem_hold       = vt[i].hold;
      redirect_valid = vt[i].redir;
      redirect_pc    = vt[i].rpc;
      #2;
      chk($sformatf("v%0d req_valid", i), {31'b0, imem_req_valid}, {31'b0, vt[i].e_req});
      if (vt[i].e_req) chk($sformatf("v%0d req_addr", i), imem_req_addr, vt[i].e_addr);
      chk($sformatf("v%0d dec_valid", i), {31'b0, dec_valid}, {31'b0, vt[i].e_dec});
      if (vt[i].e_dec) begin
        chk($sformatf("v%0d dec_pc", i), dec_pc, vt[i].e_pc);
        chk($sformatf("v%0d dec_instr", i), dec_instr, mem_word(vt[i].e_pc));
      end
      step();
    end

    // Redirect in the same cycle the request is accepted: its response is dropped
    do_reset();
    imem_req_ready = 1'b1; dec_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    #1;
    chk("racc req_addr", imem_req_addr, 32'h0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("racc dec_valid c1", {31'b0, dec_valid}, 32'd0);
    step();
    chk("racc req_addr c2", imem_req_addr, 32'h300);
    chk("racc dec_valid c2", {31'b0, dec_valid}, 32'd0);
    step();
    chk("racc dec_valid c3", {31'b0, dec_valid}, 32'd0);
    step();
    chk("racc dec_valid c4", {31'b0, dec_valid}, 32'd1);
    chk("racc dec_pc c4", dec_pc, 32'h300);
    chk("racc dec_instr c4", dec_instr, mem_word(32'h300));

    // PC wrap at top of address space
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0; imem_req_ready = 1'b1; dec_ready = 1'b1;
    #1;
    chk("wrap req_addr top", imem_req_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap req_valid wait", {31'b0, imem_req_valid}, 32'd0);
    step();
    chk("wrap req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("wrap req_addr next", imem_req_addr, 32'h0);
    chk("wrap dec_pc", dec_pc, 32'hFFFF_FFFC);

    // Reset while a request is outstanding; late response must not be delivered
    do_reset();
    imem_req_ready = 1'b1; mem_hold = 1'b1;
    step();
    rst = 1'b1;
    #1;
    chk("rmid req_valid in rst", {31'b0, imem_req_valid}, 32'd0);
    step();
    rst = 1'b0; mem_hold = 1'b0;
    #1;
    chk("rmid stale rsp seen", {31'b0, imem_rsp_valid}, 32'd1);
    chk("rmid dec_valid c0", {31'b0, dec_valid}, 32'd0);
    chk("rmid req_addr c0", imem_req_addr, 32'h0);
    step();
    chk("rmid dec_valid c1", {31'b0, dec_valid}, 32'd0);
    step();
    chk("rmid dec_valid c2", {31'b0, dec_valid}, 32'd1);
    chk("rmid dec_pc c2", dec_pc, 32'h0);
    chk("rmid dec_instr c2", dec_instr, 32'h0050_0093);

    // Misaligned redirect target
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    step();
    redirect_valid = 1'b0;
    #1;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis fault", {31'b0, fetch_fault}, 32'd1);
    chk("mis req_valid", {31'b0, imem_req_valid}, 32'd0);
`else
    chk("mis fault", {31'b0, fetch_fault}, 32'd0);
    chk("mis req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("mis req_addr", imem_req_addr, 32'h100);
`endif
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    #1;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis fault sticky", {31'b0, fetch_fault}, 32'd1);
    chk("mis req_valid halted", {31'b0, imem_req_valid}, 32'd0);
`else
    chk("mis fault after", {31'b0, fetch_fault}, 32'd0);
    chk("mis req_addr after", imem_req_addr, 32'h200);
`endif
    do_reset();
    chk("post-rst fault", {31'b0, fetch_fault}, 32'd0);
    chk("post-rst req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("post-rst req_addr", imem_req_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Instruction fetch stage of the RV32I core.
- Owns the program counter and issues word reads to instruction memory.
- Buffers returned instruction words in a small FIFO and presents {instruction, pc} to decode, which feeds the immediate extender and register file.
- Accepts taken-branch redirects from execute, flushes wrong-path instructions and restarts fetch at the target.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)
- DEPTH, 2, instruction FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  32  byte address, bits [1:0] always 0
- imem_rsp_valid  in  1  read data valid (≥1 cycle after acceptance, in order)
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  taken branch from execute
- redirect_pc  in  32  branch target
- dec_valid  out  1  instruction available to decode
- dec_ready  in  1  decode consumes this cycle
- dec_instr  out  32  instruction word (FIFO head)
- dec_pc  out  32  address of dec_instr
- fetch_fault  out  1  sticky misaligned-target fault (only with macro)

## Operation
- State machine:
  - RUN: issue requests.
  - WAIT: one request accepted, response pending.
  - HALT: fault; only with macro.
- At most one outstanding request.
- A request is raised when the FIFO free slots exceed outstanding requests, i.e. count < DEPTH in RUN.
- Request acceptance (valid && ready): move to WAIT, fetch_pc += 4 (wraps modulo 2^32).
- Response in WAIT:
  - Push {imem_rsp_data, issued pc} into the FIFO, unless the discard flag is set.
  - Return to RUN.
- Pop on dec_valid && dec_ready.
- Push and pop in the same cycle leave count unchanged.
- Redirect has priority over every simultaneous event (pop, push, acceptance):
  - FIFO is cleared, count = 0.
  - fetch_pc = target.
  - If a request is accepted-but-unanswered, or accepted in the redirect cycle, set the discard flag. The next response is dropped and the flag cleared.
- An unaccepted request may change address on redirect; imem is a sync SRAM and this is permitted by its contract.
- Responses with no outstanding request are ignored.
- Without the macro, redirect_pc[1:0] is forced to 0.
- Reset, including mid-request:
  - fetch_pc = RESET_PC, state RUN, FIFO empty, discard flag 0.
  - imem_req_valid = 0, dec_valid = 0, fetch_fault = 0.
  - dec_instr and dec_pc = 0.
  - A response arriving in the cycle after reset is dropped (discard flag forced 1 if reset hit in WAIT).

## Timing
- Reset deasserted at edge N: imem_req_valid = 1 with addr RESET_PC during cycle N.
- Response at cycle M: dec_valid = 1 at cycle M+1 (registered FIFO). There is no bypass.
- Throughput is one instruction per (memory latency + 1) cycles. With 1-cycle memory this is one instruction per 2 cycles.
- Redirect at cycle R:
  - dec_valid = 0 at R+1.
  - First request to the target at R+1 if nothing is outstanding, otherwise the cycle after the discarded response.
- dec_instr and dec_pc are stable while dec_valid && !dec_ready and no redirect.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect with redirect_pc[1:0] != 0 enters HALT and sets fetch_fault (sticky until rst).
  - The FIFO is flushed and no further requests are issued.
  - Further redirects are ignored.
- Undefined:
  - fetch_fault is tied to 0.
  - Low target bits are masked.
  - HALT is not built.

## Structure
- Shared package core_pkg:
  - XLEN = 32.
  - Fetch state enum (RUN, WAIT, HALT).
  - NOP = 32'h0000_0013.
  - Opcode constants reused by decode and sign extend.
- One sub-module: fetch_fifo, a synchronous FIFO parameterised on DEPTH and width 64, with a flush input.

## Test plan
- Reset, 1-cycle memory returning 32'h0050_0093 at 0x0:
  - request addr 0x0 in the first post-reset cycle;
  - dec_valid with dec_pc 0x0, dec_instr 32'h0050_0093 two cycles later.
- dec_ready held 0, memory always ready:
  - exactly DEPTH instructions (pc 0x0, 0x4) are buffered;
  - no further request is issued;
  - releasing dec_ready yields pc 0x0, 0x4, 0x8 in order.
- Redirect to 0x100 while the request for 0x8 is outstanding:
  - the 0x8 response is dropped;
  - the next dec_pc is 0x100;
  - no instruction from 0x4 or 0x8 appears after the redirect.
- Redirect in the same cycle as a pop and a response push:
  - FIFO ends empty;
  - the next request address is the target.
- fetch_pc 32'hFFFF_FFFC accepted: the next request address is 32'h0000_0000.
- With FETCH_MISALIGN_TRAP_EN, redirect_pc 0x102:
  - fetch_fault = 1 and imem_req_valid = 0 from the next cycle;
  - both persist until rst.
- Without the macro, the same redirect fetches 0x100.
